// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM,
// auto-repeat and a wrapping press counter.
module button_conditioner #(
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       rpt_en,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_count
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DB_PRESS   = 3'd1;
  localparam logic [2:0] HELD       = 3'd2;
  localparam logic [2:0] REPEAT     = 3'd3;
  localparam logic [2:0] DB_RELEASE = 3'd4;

  localparam logic [27:0] DB_LAST  = 28'(DB_CYCLES - 1);
  localparam logic [27:0] RD_LAST  = 28'(RPT_DELAY - 1);
  localparam logic [27:0] RP_LAST  = 28'(RPT_PERIOD - 1);

  logic        s1;
  logic        s2;
  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [27:0] cnt;
  logic [27:0] cnt_nx;
  logic        level_nx;
  logic        press_nx;
  logic        rel_nx;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Next-state, counter and pulse decisions of the debounce/repeat FSM
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 28'd1;
    level_nx = btn_level;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (s2) state_nx = DB_PRESS;
      end
      DB_PRESS: begin
        if (!s2) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = HELD;
          cnt_nx   = '0;
          level_nx = 1'b1;
          press_nx = 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_nx = DB_RELEASE;
          cnt_nx   = '0;
        end else if (!rpt_en) begin
          cnt_nx = '0;
        end else if (cnt == RD_LAST) begin
          state_nx = REPEAT;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_nx = DB_RELEASE;
          cnt_nx   = '0;
        end else if (!rpt_en) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == RP_LAST) begin
          cnt_nx   = '0;
          press_nx = 1'b1;
        end
      end
      DB_RELEASE: begin
        if (s2) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          level_nx = 1'b0;
          rel_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

  // Register FSM state, counter and all outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      btn_level   <= level_nx;
      btn_press   <= press_nx;
      btn_release <= rel_nx;
      press_count <= press_count + {7'd0, press_nx};
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner with
// a run-length reference model and an output scoreboard.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic       rpt_en = 1'b0;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  button_conditioner #(
    .DB_CYCLES(DB),
    .RPT_DELAY(RD),
    .RPT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .rpt_en(rpt_en),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .press_count(press_count)
  );

  typedef struct packed {
    logic       lvl;
    logic       prs;
    logic       rel;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   press_log[$];
  int   rel_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  bit       m_s1, m_s2, m_prev, m_lvl, m_rep;
  int       m_run, m_r;
  logic [7:0] m_cnt;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at cycle %0d",
                 name, act, exp, cyc);
    end
  endtask

  // Reference: the debounced level flips after DB+1 consecutive
  // synchronized samples disagreeing with it; repeats fire after
  // RD (then every RP) consecutive held samples with rpt_en.
  task automatic model_edge();
    exp_t e;
    bit   s, qual, prs, rel;
    prs = 0;
    rel = 0;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_lvl = 0;
      m_rep = 0; m_run = 0; m_r = 0; m_cnt = 8'd0;
    end else begin
      s = m_s2;
      qual = m_lvl && s && m_prev && rpt_en;
      if (qual) begin
        m_r++;
        if (!m_rep && m_r == RD) begin
          prs = 1; m_rep = 1; m_r = 0;
        end else if (m_rep && m_r == RP) begin
          prs = 1; m_r = 0;
        end
      end else begin
        m_r = 0;
        m_rep = 0;
      end
      if (s != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == DB + 1) begin
        m_lvl = !m_lvl;
        m_run = 0;
        if (m_lvl) prs = 1;
        else rel = 1;
      end
      if (prs) m_cnt = m_cnt + 8'd1;
      m_prev = s;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
    e.lvl = m_lvl;
    e.prs = prs;
    e.rel = rel;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic step(bit raw, bit en);
    btn_raw = raw;
    rpt_en = en;
    @(posedge clk);
    cyc++;
    model_edge();
    #7;
  endtask

  task automatic pulse_reset(int n, bit raw, bit en);
    reset = 1'b0;
    #1;
    check("rst_level", {31'd0, btn_level}, 0);
    check("rst_press", {31'd0, btn_press}, 0);
    check("rst_release", {31'd0, btn_release}, 0);
    check("rst_count", {24'd0, press_count}, 0);
    repeat (n) step(raw, en);
    reset = 1'b1;
  endtask

  // Monitor: compare every registered output against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("level", {31'd0, btn_level}, {31'd0, e.lvl});
        check("press", {31'd0, btn_press}, {31'd0, e.prs});
        check("release", {31'd0, btn_release}, {31'd0, e.rel});
        check("count", {24'd0, press_count}, {24'd0, e.cnt});
        check("excl", {31'd0, btn_press & btn_release}, 0);
        if (btn_press) press_log.push_back(cyc);
        if (btn_release) rel_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, a, len, c0;
    bit raw, en;
    int offs[6];
    offs = '{0, 20, 28, 36, 44, 52};
    @(posedge clk);
    #7;
    repeat (3) step(0, 0);
    check("reset_hold_level", {31'd0, btn_level}, 0);
    check("reset_hold_count", {24'd0, press_count}, 0);
    reset = 1'b1;
    repeat (3) step(0, 0);

    // bounce rejection
    press_log.delete();
    repeat (5) begin
      repeat (3) step(1, 0);
      repeat (3) step(0, 0);
    end
    repeat (4) step(0, 0);
    check("bounce_npress", press_log.size(), 0);
    check("bounce_level", {31'd0, btn_level}, 0);
    check("bounce_count", {24'd0, press_count}, 0);

    // clean press latency
    press_log.delete();
    k = cyc + 1;
    repeat (12) step(1, 0);
    check("clean_npress", press_log.size(), 1);
    check("clean_lat", press_log.size() > 0 ? press_log[0] : -1,
          k + 6);
    check("clean_level", {31'd0, btn_level}, 1);
    check("clean_count", {24'd0, press_count}, 1);

    // release glitch then real release
    rel_cnt = 0;
    repeat (2) step(0, 0);
    repeat (6) step(1, 0);
    check("glitch_nrel", rel_cnt, 0);
    check("glitch_level", {31'd0, btn_level}, 1);
    repeat (8) step(0, 0);
    check("release_nrel", rel_cnt, 1);
    check("release_level", {31'd0, btn_level}, 0);

    // auto-repeat
    press_log.delete();
    k = cyc + 1;
    a = k + 6;
    while (cyc < a + 56) step(1, 1);
    repeat (10) step(0, 1);
    check("rpt_npress", press_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check("rpt_offset",
            press_log.size() > i ? press_log[i] - a : -1, offs[i]);
    check("rpt_count", {24'd0, press_count}, 7);

    // randomized bursts
    repeat (80) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45)
                                         : $urandom_range(1, 8);
      raw = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      repeat (len) step(raw, en);
    end
    repeat (10) step(0, 0);

    // reset mid-repeat with the button still held
    press_log.delete();
    k = cyc + 1;
    repeat (31) step(1, 1);
    check("pre_rst_npress", press_log.size(), 2);
    pulse_reset(3, 1, 1);
    press_log.delete();
    k = cyc + 1;
    repeat (10) step(1, 1);
    check("post_rst_npress", press_log.size(), 1);
    check("post_rst_lat", press_log.size() > 0 ? press_log[0] : -1,
          k + 6);
    check("post_rst_count", {24'd0, press_count}, 1);

    // counter wrap after 256 presses
    step(0, 0);
    pulse_reset(2, 0, 0);
    repeat (2) step(0, 0);
    for (int i = 0; i < 256; i++) begin
      repeat (8) step(1, 0);
      repeat (8) step(0, 0);
      if (i == 254) check("wrap_255", {24'd0, press_count}, 255);
    end
    check("wrap_0", {24'd0, press_count}, 0);
    check("wrap_level", {31'd0, btn_level}, 0);

    repeat (3) step(0, 0);
    c0 = sb.size();
    check("sb_drained", c0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
